milley_decoder: RTL and testbench
=================================

# milley_decoder

Inverse (decoder) for the lab's 4-state Mealy automaton. It consumes the stream of output symbols the automaton writes and reconstructs the input symbols that produced them, tracking the automaton state. It resolves the one non-invertible transition with one-symbol lookahead and flags illegal symbol sequences. It sits on the receive side of the SyncAutomates lab, fed by the automaton's output strobe.

## Interface
- No parameters.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- sym_valid  in  1  sym carries one automaton output write this cycle
- sym  in  2  automaton output symbol, B1..B4 = 0..3
- sym_ready  out  1  decoder accepts sym this cycle; transfer = sym_valid & sym_ready
- a_valid  out  1  one-cycle strobe, a holds a decoded input symbol
- a  out  2  decoded input symbol, A1..A3 = 1..3
- state  out  2  tracked automaton state, C1..C4 = 0..3
- pending  out  1  last accepted symbol is unresolved (C4/C2 ambiguity)
- err  out  1  one-cycle pulse on an illegal symbol
- err_cnt  out  8  count of illegal symbols, saturates at 255

## Operation
- Decode table for an accepted sym in state S, listed as sym -> decoded a, next state:
  - C1: 1 -> A1, C1. 2 -> A2, C2. 3 -> A3, C3. 0 is illegal.
  - C2: 0 -> A3, C1. 1, 2 and 3 are illegal.
  - C3: 0 -> A1, C4. 2 -> A2, C1. 3 -> A3, C2. 1 is illegal.
  - C4, not pending: 1 -> set pending, no output. 0, 2 and 3 are illegal.
  - Pending: 1 -> emit A1 for the held symbol, stay C4, keep pending.
  - Pending: 0 -> emit A3 for the held symbol, then A3 for the current symbol, go to C1, clear pending.
  - Pending: 2 or 3 is illegal.
- In C1, sym 1 always decodes as A1. The automaton's idle input (0) is indistinguishable from A1 and is reported as A1.
- The double emit (pending resolved by 0) uses a one-entry hold register:
  - First A3 goes to the output.
  - Second A3 is held and drains on the next cycle.
  - sym_ready = !hold_full.
- On an illegal symbol:
  - err pulses for one cycle and err_cnt increments (saturating at 255).
  - state is forced to C1 and pending clears.
  - The unresolved held symbol is discarded and never emitted, and no a_valid is produced.
- A symbol left pending at end of stream stays pending indefinitely; it is resolved only by the next symbol or by reset.
- Cycles with sym_valid low change nothing except draining the hold register.
- Held automaton outputs (no write) never reach the decoder, so they are not decoded.

## Timing
- Reset values: state = C1, pending = 0, hold empty, sym_ready = 1, a_valid = 0, a = 0, err = 0, err_cnt = 0.
- All outputs are registered except sym_ready, which is a decode of the hold_full register.
- Latency: a symbol accepted at edge k produces a_valid/a, err and the updated state/pending visible after edge k, i.e. in cycle k+1.
- Pending symbol: its a appears in the cycle after the resolving symbol is accepted.
- Double emit with the resolving 0 accepted at edge k:
  - a_valid = 1, a = 3 in cycle k+1, with sym_ready = 0 in that cycle.
  - a_valid = 1, a = 3 again in cycle k+2, with sym_ready = 1.
- sym_valid while sym_ready = 0: the symbol is not accepted; the source must hold it.
- Reset asserted mid-operation (including with the hold register full) clears everything at once; the held A3 is never emitted.
- err_cnt at 255 stays at 255 on further errors, while err still pulses.

## Test plan
- Reset, then syms 2, 0 -> a = 2, then a = 3; state C2, then C1; no err.
- Syms 3, 0, 1, 1, 0 -> a = 3, 1, (none, pending = 1), 1, then 3, 3 on consecutive cycles:
  - sym_ready low for exactly one cycle.
  - Final state C1, pending = 0.
- Reach C2 (sym 2), then send sym 1 -> err pulse, err_cnt = 1, state C1, no a_valid; next sym 3 -> a = 3, state C3.
- From pending (syms 3, 0, 1), send sym 2 -> err, pending = 0, state C1; held symbol never emitted.
- Double emit in progress (hold full), drop reset low for one cycle -> second a_valid suppressed; all outputs at reset values; sym_ready = 1.
- 260 illegal syms (sym 0 in C1) -> 260 err pulses, err_cnt = 255, no a_valid.

Source files
------------

// File: rtl/milley_decoder.sv
// rtl/milley_decoder.sv - inverse of the lab 4-state Mealy automaton with one-symbol lookahead
module milley_decoder (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sym_valid_i,
    input  logic [1:0] sym_i,
    output logic       sym_ready_o,
    output logic       a_valid_o,
    output logic [1:0] a_o,
    output logic [1:0] state_o,
    output logic       pending_o,
    output logic       err_o,
    output logic [7:0] err_cnt_o
);

    localparam logic [1:0] C1 = 2'd0;
    localparam logic [1:0] C2 = 2'd1;
    localparam logic [1:0] C3 = 2'd2;
    localparam logic [1:0] C4 = 2'd3;

    localparam logic [1:0] A1 = 2'd1;
    localparam logic [1:0] A2 = 2'd2;
    localparam logic [1:0] A3 = 2'd3;

    logic [1:0] state_q, state_d;
    logic       pending_q, pending_d;
    // The hold register only ever holds the second A3 of a resolved pending
    // symbol, so a full flag is all the storage it needs.
    logic       hold_full_q, hold_full_d;

    logic       a_valid_q, a_valid_d;
    logic [1:0] a_q, a_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       accept;
    logic       illegal;
    logic       emit;
    logic [1:0] emit_a;

    assign accept = sym_valid_i & ~hold_full_q;

    // Tracked automaton state, lookahead flag and hold register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= C1;
            pending_q   <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Decode the accepted symbol against the current state, or drain the hold register
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hold_full_d = hold_full_q;
        illegal     = 1'b0;
        emit        = 1'b0;
        emit_a      = 2'd0;
        if (hold_full_q) begin
            hold_full_d = 1'b0;
            emit        = 1'b1;
            emit_a      = A3;
        end else if (accept) begin
            case (state_q)
                C1: begin
                    // Sym 1 covers both A1 and the automaton's idle input.
                    if (sym_i == 2'd0) begin
                        illegal = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        emit_a  = sym_i;
                        state_d = sym_i - 2'd1;
                    end
                end
                C2: begin
                    if (sym_i == 2'd0) begin
                        emit    = 1'b1;
                        emit_a  = A3;
                        state_d = C1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                C3: begin
                    case (sym_i)
                        2'd0: begin emit = 1'b1; emit_a = A1; state_d = C4; end
                        2'd2: begin emit = 1'b1; emit_a = A2; state_d = C1; end
                        2'd3: begin emit = 1'b1; emit_a = A3; state_d = C2; end
                        default: illegal = 1'b1;
                    endcase
                end
                default: begin
                    // C4: a 1 is ambiguous until the next symbol shows whether
                    // the automaton stayed in C4 (A1) or left to C1 (A3).
                    if (!pending_q) begin
                        if (sym_i == 2'd1) pending_d = 1'b1;
                        else               illegal   = 1'b1;
                    end else begin
                        case (sym_i)
                            2'd1: begin
                                emit   = 1'b1;
                                emit_a = A1;
                            end
                            2'd0: begin
                                emit        = 1'b1;
                                emit_a      = A3;
                                hold_full_d = 1'b1;
                                state_d     = C1;
                                pending_d   = 1'b0;
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
                end
            endcase
            if (illegal) begin
                state_d   = C1;
                pending_d = 1'b0;
            end
        end
    end

    // Next values of the registered outputs
    always_comb begin
        a_valid_d = emit;
        a_d       = emit ? emit_a : a_q;
        err_d     = illegal;
        err_cnt_d = (illegal && (err_cnt_q != 8'hff)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            a_q       <= 2'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            a_valid_q <= a_valid_d;
            a_q       <= a_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sym_ready_o = ~hold_full_q;
    assign a_valid_o   = a_valid_q;
    assign a_o         = a_q;
    assign state_o     = state_q;
    assign pending_o   = pending_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_milley_decoder.sv
// tb/tb_milley_decoder.sv - randomized self-checking bench for milley_decoder
module tb_milley_decoder;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       sym_valid_i = 1'b0;
    logic [1:0] sym_i = 2'd0;
    logic       sym_ready_o;
    logic       a_valid_o;
    logic [1:0] a_o;
    logic [1:0] state_o;
    logic       pending_o;
    logic       err_o;
    logic [7:0] err_cnt_o;

    milley_decoder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sym_valid_i (sym_valid_i),
        .sym_i       (sym_i),
        .sym_ready_o (sym_ready_o),
        .a_valid_o   (a_valid_o),
        .a_o         (a_o),
        .state_o     (state_o),
        .pending_o   (pending_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Automaton inverse as a table: decoded input (-1 illegal, 0 = go pending)
    // and next state, indexed [state][sym].
    int tab_a [4][4] = '{'{-1, 1, 2, 3}, '{3, -1, -1, -1}, '{1, -1, 2, 3}, '{-1, 0, -1, -1}};
    int tab_n [4][4] = '{'{0, 0, 1, 2},  '{0, 0, 0, 0},    '{3, 0, 0, 1},  '{3, 3, 3, 3}};

    // Reference model: decoded symbols not yet shown wait in a backlog.
    int m_state;
    bit m_pend;
    bit m_av;
    int m_a;
    bit m_err;
    int m_cnt;
    int backlog[$];

    logic [15:0] obs;
    assign obs = {sym_ready_o, a_valid_o, a_o, state_o, pending_o, err_o, err_cnt_o};

    function automatic logic [15:0] exp_vec();
        logic ready;
        logic [1:0] a2, s2;
        logic [7:0] c8;
        ready = (backlog.size() == 0);
        a2 = m_a[1:0];
        s2 = m_state[1:0];
        c8 = m_cnt[7:0];
        return {ready, m_av, a2, s2, m_pend, m_err, c8};
    endfunction

    task automatic model_reset();
        m_state = 0; m_pend = 0; m_av = 0; m_a = 0; m_err = 0; m_cnt = 0;
        backlog.delete();
    endtask

    task automatic step(input bit v, input int s);
        bit acc;
        int outs[$];
        sym_valid_i = v;
        sym_i = s[1:0];
        acc = v && (backlog.size() == 0);
        @(posedge clk_i);
        m_av = 0;
        m_err = 0;
        if (backlog.size() != 0) begin
            outs.push_back(backlog.pop_front());
        end else if (acc) begin
            if (m_pend) begin
                if (s == 1) outs.push_back(1);
                else if (s == 0) begin
                    outs.push_back(3); outs.push_back(3);
                    m_state = 0; m_pend = 0;
                end else m_err = 1;
            end else if (tab_a[m_state][s] < 0) begin
                m_err = 1;
            end else begin
                if (tab_a[m_state][s] == 0) m_pend = 1;
                else outs.push_back(tab_a[m_state][s]);
                m_state = tab_n[m_state][s];
            end
            if (m_err) begin
                m_state = 0; m_pend = 0;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (outs.size() != 0) begin
            m_av = 1;
            m_a = outs.pop_front();
            while (outs.size() != 0) backlog.push_back(outs.pop_front());
        end
        #1;
        sym_valid_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        tests++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_held: got %h want %h", obs, exp_vec());
        end
        rst_ni = 1;
        step(0, 0);
        tests++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic();
        int seq[2] = '{2, 0};
        for (int i = 0; i < 2; i++) begin
            step(1, seq[i]);
            tests++;
            if (obs !== exp_vec() || a_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL basic[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_pending();
        int seq[6] = '{3, 0, 1, 1, 0, -1};
        int low = 0;
        for (int i = 0; i < 6; i++) begin
            if (seq[i] < 0) step(0, 0);
            else step(1, seq[i]);
            if (sym_ready_o === 1'b0) low++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL pending[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (low != 1 || state_o !== 2'd0 || pending_o !== 1'b0) begin
            fails++;
            $display("FAIL pending_end: got ready_low=%0d state=%0d pend=%0b want 1 0 0", low, state_o, pending_o);
        end
    endtask

    task automatic test_illegal_c2();
        int seq[3] = '{2, 1, 3};
        int c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1, seq[i]);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL illegal_c2[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (err_cnt_o !== 8'(c0 + 1) || state_o !== 2'd2) begin
            fails++;
            $display("FAIL illegal_c2_end: got cnt=%0d state=%0d want %0d 2", err_cnt_o, state_o, c0 + 1);
        end
    endtask

    task automatic test_illegal_pending();
        int seq[5] = '{2, 0, 3, 0, 1};
        for (int i = 0; i < 5; i++) step(1, seq[i]);
        step(1, 2);
        tests++;
        if (obs !== exp_vec() || err_o !== 1'b1 || a_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL illegal_pending: got %h want %h", obs, exp_vec());
        end
        step(0, 0);
        tests++;
        if (obs !== exp_vec() || a_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL illegal_pending_after: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_hold();
        int seq[4] = '{3, 0, 1, 0};
        for (int i = 0; i < 4; i++) step(1, seq[i]);
        tests++;
        if (obs !== exp_vec() || sym_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_full: got %h want %h", obs, exp_vec());
        end
        rst_ni = 0;
        model_reset();
        #1;
        tests++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_async: got %h want %h", obs, exp_vec());
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        step(0, 0);
        tests++;
        if (obs !== exp_vec() || a_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold_drain: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        int bad = 0;
        for (int i = 0; i < 260; i++) begin
            step(1, 0);
            if (err_o === 1'b1) pulses++;
            if (obs !== exp_vec()) bad++;
        end
        tests++;
        if (bad != 0 || pulses != 260 || err_cnt_o !== 8'd255) begin
            fails++;
            $display("FAIL saturate: got bad=%0d pulses=%0d cnt=%0d want 0 260 255", bad, pulses, err_cnt_o);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int s;
        for (int i = 0; i < 2000; i++) begin
            s = $urandom_range(0, 3);
            if ($urandom_range(0, 7) != 0) begin
                for (int t = 0; t < 16; t++) begin
                    if (m_pend ? (s <= 1) : (tab_a[m_state][s] >= 0)) break;
                    s = $urandom_range(0, 3);
                end
            end
            step($urandom_range(0, 3) != 0, s);
            if (obs !== exp_vec()) begin
                bad++;
                if (bad <= 5) $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL random_total: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_illegal_c2();
        test_illegal_pending();
        test_reset_hold();
        test_reset();
        test_saturate();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
